coin_pulse_gen: RTL and testbench
=================================

Name: coin_pulse_gen

Overview:
Upstream conditioning stage for the vending-machine Mealy FSM. It converts two raw, asynchronous, bouncing coin-sensor levels into clean, synchronous, single-cycle `in5`/`in10` pulses. Those pulses drive the FSM's coin inputs directly. It also guarantees the two pulses are never asserted in the same cycle, and flags a jammed sensor.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples needed to accept a press or a release. Must be >= 2.
- JAM_CYCLES, 64: consecutive high cycles in the HELD state after which the channel is declared jammed. Must be > DEBOUNCE_CYCLES.
- CNT_W, 8: counter width. Must satisfy 2^CNT_W > JAM_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- coin5_raw  input  1  raw 5-unit coin sensor, asynchronous, may bounce.
- coin10_raw  input  1  raw 10-unit coin sensor, asynchronous, may bounce.
- in5  output  1  registered single-cycle pulse: one accepted 5-unit coin.
- in10  output  1  registered single-cycle pulse: one accepted 10-unit coin.
- jam  output  1  registered level: at least one channel is jammed.

Behaviour:
- Clocking and reset:
  - Single clock domain `clk`.
  - `reset` is asynchronous and active-high. While it is asserted, all flops clear: synchronizers 0, channel FSMs IDLE, counters 0, pending flag 0, `in5`=0, `in10`=0, `jam`=0.
- Synchronization: each raw input passes through a 2-flop synchronizer. Call the result `s5`/`s10`. Everything below uses only `s*`.
- Per-channel FSM (identical for both channels), with a counter `cnt`:
  - IDLE: if `s`=1, go to PRESS with `cnt`=1.
  - PRESS: if `s`=0, go to IDLE with `cnt`=0 (this is a bounce). Else if `cnt`==DEBOUNCE_CYCLES, go to HELD, raise a one-cycle request `req`, and set `cnt`=0. Else increment `cnt`.
  - HELD:
    - If `s`=0, increment the release count; if it reaches DEBOUNCE_CYCLES, go to IDLE.
    - If `s`=1, reset the release count and increment the high count. If the high count reaches JAM_CYCLES, go to JAMMED.
    - No further `req` is raised while in HELD.
  - JAMMED: the channel's jam bit is 1. Leave only after DEBOUNCE_CYCLES consecutive `s`=0 samples; go to IDLE, which clears the jam bit. Nothing is pulsed on exit.
- Latency: for a clean raw rising edge sampled at clock edge k, the output pulse is high during the cycle following edge k+2+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=4, that is edge k+6.
- One coin, one pulse: each accepted press produces exactly one output pulse, however long the sensor is then held.
- Arbiter and output register:
  - `req10` only: `in10`=1 next cycle.
  - `req5` only: `in5`=1 next cycle, unless the pending flag is set.
  - Both in the same cycle: `in10`=1 next cycle, the pending flag is set, and `in5`=1 the cycle after; the pending flag then clears.
  - Pending-flag set (no new `req5`): `in5`=1 next cycle; the flag clears.
  - `in5` and `in10` are never both 1 in the same cycle.
  - No coin is ever dropped. Consecutive same-channel requests are separated by at least 2*DEBOUNCE_CYCLES cycles, so one pending bit is sufficient.
- `jam` = registered OR of both channel jam bits. A jam on one channel does not block the other channel.
- Reset mid-operation: a pending pulse or partially debounced press is discarded. No pulse is emitted after reset deasserts until a fresh press is debounced.

Decomposition:
- Shared package (`coin_pkg`):
  - channel-state typedef/localparams: IDLE, PRESS, HELD, JAMMED;
  - default DEBOUNCE_CYCLES / JAM_CYCLES constants.
- One sub-module, `coin_debounce`, instantiated twice. It contains the synchronizer, the channel FSM and the counters, and outputs `req` and `jam_ch`.
- The top level holds the arbiter, the pending flag and the output registers.

Test Plan (clk period 2 ns, DEBOUNCE_CYCLES=4, JAM_CYCLES=64):
- Reset held 5 ns, then raw inputs held 0 for 20 ns -> `in5`=`in10`=`jam`=0 throughout. Asserting reset mid-PRESS -> no pulse follows.
- `coin10_raw` 0->1 clean, held 20 ns -> exactly one `in10` pulse of 1 cycle, 6 edges after the sampling edge, and no `in5`.
- `coin5_raw` bouncing 1,0,1,0 every cycle for 6 cycles, then low -> no pulse. Bouncing, then stable high for 10 cycles -> exactly one `in5` pulse.
- `coin5_raw` and `coin10_raw` rising on the same edge, both clean -> `in10` pulse in cycle N, `in5` pulse in cycle N+1, never overlapping.
- `coin5_raw` held high 200 ns -> one `in5` pulse, then `jam`=1 after 64 HELD cycles. A `coin10_raw` press during the jam still yields one `in10`. `coin5_raw` low for 4 cycles -> `jam`=0, no extra `in5`.
- Four sequential presses alternating 10,5,5,10, each 10 ns high with 10 ns gaps -> pulse sequence `in10`, `in5`, `in5`, `in10`, one cycle each, matching the downstream vending FSM's expected coin order.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared constants and channel-state encoding for the coin conditioning stage.
`timescale 1ns/1ps
package coin_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_JAM_CYCLES      = 64;
  localparam int DEF_CNT_W           = 8;

  typedef logic [1:0] ch_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRESS  = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;
  localparam logic [1:0] ST_JAMMED = 2'd3;

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchronizer, debounce FSM, one-shot request and jam flag.
//
// state  | meaning
// IDLE   | sensor released, waiting for a high sample
// PRESS  | counting consecutive high samples toward acceptance
// HELD   | press accepted; watching for release or a stuck-high sensor
// JAMMED | sensor stuck high; waits for a debounced release
`timescale 1ns/1ps
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int JAM_CYCLES      = DEF_JAM_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic req_o,
  output logic jam_ch_o
);

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] JAM_C = CNT_W'(JAM_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic             sync1_q;
  logic             s_q;
  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] rel_inc;
  logic             req_d;

  assign cnt_inc = cnt_q + ONE_C;
  assign rel_inc = rel_q + ONE_C;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    req_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rel_d = '0;
        if (s_q) begin
          state_d = ST_PRESS;
          cnt_d   = ONE_C;
        end else begin
          cnt_d = '0;
        end
      end
      ST_PRESS: begin
        if (!s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d = ST_HELD;
          req_d   = 1'b1;
          cnt_d   = '0;
          rel_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        // cnt_q tracks high samples, rel_q tracks consecutive low samples
        if (!s_q) begin
          if (rel_inc == DEB_C) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rel_d   = '0;
          end else begin
            rel_d = rel_inc;
          end
        end else begin
          rel_d = '0;
          if (cnt_inc == JAM_C) begin
            state_d = ST_JAMMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_JAMMED: begin
        if (!s_q) begin
          if (rel_inc == DEB_C) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rel_d   = '0;
          end else begin
            rel_d = rel_inc;
          end
        end else begin
          rel_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
    end
  end

  // Combinational so the top's output register lands the pulse on the accepting edge.
  assign req_o    = req_d;
  assign jam_ch_o = (state_q == ST_JAMMED);

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin input conditioner: two debounced channels feeding a 10-first arbiter that
// defers a colliding 5-unit pulse by one cycle, plus a registered jam summary.
`timescale 1ns/1ps
module coin_pulse_gen
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int JAM_CYCLES      = DEF_JAM_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic coin5_raw,
  input  logic coin10_raw,
  output logic in5,
  output logic in10,
  output logic jam
);

  logic req5, req10;
  logic jam5, jam10;
  logic pend_q, pend_d;
  logic in5_q, in5_d;
  logic in10_q, in10_d;
  logic jam_q, jam_d;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch5 (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (coin5_raw),
    .req_o    (req5),
    .jam_ch_o (jam5)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch10 (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (coin10_raw),
    .req_o    (req10),
    .jam_ch_o (jam10)
  );

  always_comb begin
    in5_d  = 1'b0;
    in10_d = 1'b0;
    pend_d = 1'b0;
    if (req10) begin
      in10_d = 1'b1;
      pend_d = pend_q | req5;
    end else if (pend_q) begin
      // a fresh req5 here re-arms the flag so it is still not dropped
      in5_d  = 1'b1;
      pend_d = req5;
    end else begin
      in5_d = req5;
    end
    jam_d = jam5 | jam10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
      in5_q  <= 1'b0;
      in10_q <= 1'b0;
      jam_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      in5_q  <= in5_d;
      in10_q <= in10_d;
      jam_q  <= jam_d;
    end
  end

  assign in5  = in5_q;
  assign in10 = in10_q;
  assign jam  = jam_q;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Directed bench: per-cycle vector table for the main scenarios, hand-written
// sequences for reset during a press and reset with a deferred 5-unit pulse.
`timescale 1ns/1ps
module tb_coin_pulse_gen;

  logic clk;
  logic reset;
  logic coin5_raw;
  logic coin10_raw;
  logic in5;
  logic in10;
  logic jam;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r5;
    logic       r10;
    logic [2:0] exp;   // {in5, in10, jam} after the edge that samples r5/r10
    int         sec;
  } vec_t;

  vec_t  vecs[$];
  string sec_name [6] = '{"idle", "clean10", "bounce5", "both", "jam5", "alt_seq"};

  coin_pulse_gen dut (
    .clk        (clk),
    .reset      (reset),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .in5        (in5),
    .in10       (in10),
    .jam        (jam)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic add_vec(input int sec, input logic r5, input logic r10,
                         input logic e5, input logic e10, input logic ej, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.r5  = r5;
      v.r10 = r10;
      v.exp = {e5, e10, ej};
      v.sec = sec;
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string nm, input int idx, input logic [2:0] exp);
    logic [2:0] act;
    act = {in5, in10, jam};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] in5/in10/jam got %b expected %b at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic step(input logic r5, input logic r10);
    coin5_raw  = r5;
    coin10_raw = r10;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_press(input int sec, input logic r5, input logic r10);
    add_vec(sec, r5, r10, 1'b0, 1'b0, 1'b0, 5);
    add_vec(sec, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add_vec(sec, 1'b0, 1'b0, r5, r10, 1'b0, 1);
    add_vec(sec, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
  endtask

  initial begin
    reset      = 1'b1;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;

    // idle after reset: 20 ns of quiet inputs
    add_vec(0, 0, 0, 0, 0, 0, 10);
    // clean 10-unit press, 10 cycles high: pulse on the 6th edge after sampling
    add_vec(1, 0, 1, 0, 0, 0, 6);
    add_vec(1, 0, 1, 0, 1, 0, 1);
    add_vec(1, 0, 1, 0, 0, 0, 3);
    add_vec(1, 0, 0, 0, 0, 0, 8);
    // pure bounce then low: nothing
    for (int i = 0; i < 3; i++) begin
      add_vec(2, 1, 0, 0, 0, 0, 1);
      add_vec(2, 0, 0, 0, 0, 0, 1);
    end
    add_vec(2, 0, 0, 0, 0, 0, 6);
    // bounce, then stable high from the 5th vector: pulse 6 edges later
    add_vec(2, 1, 0, 0, 0, 0, 1);
    add_vec(2, 0, 0, 0, 0, 0, 1);
    add_vec(2, 1, 0, 0, 0, 0, 1);
    add_vec(2, 0, 0, 0, 0, 0, 1);
    add_vec(2, 1, 0, 0, 0, 0, 6);
    add_vec(2, 1, 0, 1, 0, 0, 1);
    add_vec(2, 1, 0, 0, 0, 0, 3);
    add_vec(2, 0, 0, 0, 0, 0, 8);
    // simultaneous press: in10 then in5 on the next cycle
    add_vec(3, 1, 1, 0, 0, 0, 6);
    add_vec(3, 1, 1, 0, 1, 0, 1);
    add_vec(3, 1, 1, 1, 0, 0, 1);
    add_vec(3, 1, 1, 0, 0, 0, 2);
    add_vec(3, 0, 0, 0, 0, 0, 8);
    // 5-unit held 100 cycles: one pulse, jam after 64 HELD cycles, 10 still accepted
    add_vec(4, 1, 0, 0, 0, 0, 6);
    add_vec(4, 1, 0, 1, 0, 0, 1);
    add_vec(4, 1, 0, 0, 0, 0, 64);
    add_vec(4, 1, 0, 0, 0, 1, 9);
    add_vec(4, 1, 1, 0, 0, 1, 5);
    add_vec(4, 1, 0, 0, 0, 1, 1);
    add_vec(4, 1, 0, 0, 1, 1, 1);
    add_vec(4, 1, 0, 0, 0, 1, 13);
    add_vec(4, 0, 0, 0, 0, 1, 6);
    add_vec(4, 0, 0, 0, 0, 0, 10);
    // alternating presses 10,5,5,10: 10 ns high, 10 ns gap
    add_press(5, 0, 1);
    add_press(5, 1, 0);
    add_press(5, 1, 0);
    add_press(5, 0, 1);

    #2;
    check("in_reset", 0, 3'b000);
    #3;
    reset = 1'b0;
    @(negedge clk);

    begin
      int base;
      int prev;
      base = 0;
      prev = -1;
      foreach (vecs[i]) begin
        if (vecs[i].sec != prev) begin
          base = i;
          prev = vecs[i].sec;
        end
        step(vecs[i].r5, vecs[i].r10);
        check(sec_name[vecs[i].sec], i - base, vecs[i].exp);
      end
    end

    // reset while channel 5 is mid-PRESS: press is discarded
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check("rst_press_pre", i, 3'b000);
    end
    reset     = 1'b1;
    coin5_raw = 1'b0;
    #0.2;
    check("rst_press_async", 0, 3'b000);
    @(negedge clk);
    step(1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      check("rst_press_post", i, 3'b000);
    end

    // reset right as in10 fires: the deferred in5 must never appear
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
    end
    step(1'b1, 1'b1);
    check("pend_pre", 0, 3'b010);
    reset      = 1'b1;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    #0.2;
    check("pend_rst_async", 0, 3'b000);
    @(negedge clk);
    step(1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check("pend_rst_post", i, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
